// File: rtl/radio_deserializer_if.sv
// Radio link receive bundle: serial pins and clear in, recovered word and link status out.
// The bench side drives the pins (master); the deserializer consumes them (slave).
interface radio_deserializer_if #(
  parameter int WORD_BITS = 8,
  parameter int ERR_W     = 16
);
  logic                 dataIn;
  logic                 syncIn;
  logic                 clrErr;
  logic [WORD_BITS-1:0] wordOut;
  logic                 wordValid;
  logic                 locked;
  logic [ERR_W-1:0]     syncErrCnt;

  modport master (
    output dataIn, syncIn, clrErr,
    input  wordOut, wordValid, locked, syncErrCnt
  );

  modport slave (
    input  dataIn, syncIn, clrErr,
    output wordOut, wordValid, locked, syncErrCnt
  );
endinterface

// File: rtl/radio_deserializer.sv
// Serial link receiver: frames LSB-first words on SYNC, proves alignment over several frames,
// then emits parallel words with a one-cycle strobe and counts sync violations while locked.
module radio_deserializer #(
  parameter int WORD_BITS   = 8,
  parameter int LOCK_FRAMES = 4,
  parameter int ERR_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  radio_deserializer_if.slave link
);

  localparam int POS_W  = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(WORD_BITS - 1);
  localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES);
  localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // With a single-frame lock requirement a fresh SYNC is already proof of alignment.
  localparam state_e FIRST_SYNC_STATE = (LOCK_FRAMES == 1) ? LOCKED : VERIFY;

  logic                 dQ, dD;
  logic                 sQ, sD;
  logic [WORD_BITS-2:0] srQ, srD;
  logic [POS_W-1:0]     posQ, posD;
  logic [GOOD_W-1:0]    goodQ, goodD;
  state_e               stateQ, stateD;
  logic [WORD_BITS-1:0] wordQ, wordD;
  logic                 validQ, validD;
  logic                 lockedQ, lockedD;
  logic [ERR_W-1:0]     errQ, errD;

  logic                 mismatch;
  logic                 errCount;
  logic [POS_W-1:0]     posNext;
  logic [WORD_BITS-1:0] srWide;

  always_comb begin
    dD       = link.dataIn;
    sD       = link.syncIn;
    srWide   = {dQ, srQ};
    srD      = srWide[WORD_BITS-1:1];
    mismatch = sQ ^ (posQ == '0);
    posNext  = (posQ == POS_LAST) ? '0 : posQ + POS_ONE;

    stateD   = stateQ;
    posD     = posQ;
    goodD    = goodQ;
    wordD    = wordQ;
    validD   = 1'b0;
    errCount = 1'b0;

    unique case (stateQ)
      HUNT: begin
        posD  = '0;
        goodD = '0;
        if (sQ) begin
          stateD = FIRST_SYNC_STATE;
          posD   = POS_ONE;
          goodD  = GOOD_ONE;
        end
      end

      VERIFY: begin
        if (mismatch) begin
          stateD = sQ ? FIRST_SYNC_STATE : HUNT;
          posD   = sQ ? POS_ONE : '0;
          goodD  = sQ ? GOOD_ONE : '0;
        end else begin
          posD = posNext;
          if (sQ) begin
            goodD = goodQ + GOOD_ONE;
            if (goodD == GOOD_LOCK) begin
              stateD = LOCKED;
            end
          end
        end
      end

      LOCKED: begin
        // A broken frame drops lock and discards the word in flight.
        if (mismatch) begin
          errCount = 1'b1;
          stateD   = sQ ? FIRST_SYNC_STATE : HUNT;
          posD     = sQ ? POS_ONE : '0;
          goodD    = sQ ? GOOD_ONE : '0;
        end else begin
          posD = posNext;
          if (posQ == POS_LAST) begin
            wordD  = srWide;
            validD = 1'b1;
          end
        end
      end

      default: begin
        stateD = HUNT;
        posD   = '0;
        goodD  = '0;
      end
    endcase

    lockedD = (stateD == LOCKED);

    if (link.clrErr) begin
      errD = errCount ? ERR_ONE : '0;
    end else if (errCount && !(&errQ)) begin
      errD = errQ + ERR_ONE;
    end else begin
      errD = errQ;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dQ      <= 1'b0;
      sQ      <= 1'b0;
      srQ     <= '0;
      posQ    <= '0;
      goodQ   <= '0;
      stateQ  <= HUNT;
      wordQ   <= '0;
      validQ  <= 1'b0;
      lockedQ <= 1'b0;
      errQ    <= '0;
    end else begin
      dQ      <= dD;
      sQ      <= sD;
      srQ     <= srD;
      posQ    <= posD;
      goodQ   <= goodD;
      stateQ  <= stateD;
      wordQ   <= wordD;
      validQ  <= validD;
      lockedQ <= lockedD;
      errQ    <= errD;
    end
  end

  assign link.wordOut    = wordQ;
  assign link.wordValid  = validQ;
  assign link.locked     = lockedQ;
  assign link.syncErrCnt = errQ;

endmodule

// File: tb/tb_radio_deserializer.sv
// Directed bench for radio_deserializer: lock, bit order, misplaced/missing SYNC,
// error counter saturation and clear, and asynchronous reset mid-word.
module tb_radio_deserializer;

  localparam int WORD_BITS   = 8;
  localparam int LOCK_FRAMES = 4;
  localparam int ERR_W       = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  radio_deserializer_if #(.WORD_BITS(WORD_BITS), .ERR_W(ERR_W)) link ();

  radio_deserializer #(
    .WORD_BITS  (WORD_BITS),
    .LOCK_FRAMES(LOCK_FRAMES),
    .ERR_W      (ERR_W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .link  (link)
  );

  int checks   = 0;
  int failures = 0;

  int cyc         = 0;
  int lockRiseCyc = -1;
  int lockFallCyc = -1;
  int pulseErr    = 0;
  int lastSyncCyc = -1;
  int lastBit0Cyc = -1;

  logic [7:0]       rxQ[$];
  int               rxCyc[$];
  logic             prevValid = 1'b0;
  logic             prevLocked = 1'b0;
  logic             obsValid, obsLocked;
  logic [7:0]       obsWordOut;
  logic [ERR_W-1:0] obsErr;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] rxAt(input int i);
    if (i < rxQ.size()) return rxQ[i];
    return 8'hxx;
  endfunction

  function automatic int cycAt(input int i);
    if (i < rxCyc.size()) return rxCyc[i];
    return -1;
  endfunction

  // One bit time: sample outputs on the falling edge, log strobes/lock edges, then drive pins.
  task automatic applyStimulus(input logic d, input logic s, input logic clr);
    @(negedge clk);
    cyc++;
    obsValid   = link.wordValid;
    obsLocked  = link.locked;
    obsWordOut = link.wordOut;
    obsErr     = link.syncErrCnt;
    if (obsValid) begin
      rxQ.push_back(obsWordOut);
      rxCyc.push_back(cyc);
      if (prevValid) pulseErr++;
    end
    if (obsLocked && !prevLocked) lockRiseCyc = cyc;
    if (!obsLocked && prevLocked) lockFallCyc = cyc;
    prevValid   = obsValid;
    prevLocked  = obsLocked;
    link.dataIn = d;
    link.syncIn = s;
    link.clrErr = clr;
  endtask

  task automatic sendWord(input logic [7:0] w, input logic [7:0] syncMask, input int clrAt);
    for (int b = 0; b < 8; b++) begin
      applyStimulus(w[b], syncMask[b], (b == clrAt));
      if (syncMask[b]) lastSyncCyc = cyc;
      if (b == 0) lastBit0Cyc = cyc;
    end
  endtask

  task automatic clearRx();
    rxQ.delete();
    rxCyc.delete();
  endtask

  int c3, cMis, cX, c13, c66, c23;

  initial begin
    link.dataIn = 1'b0;
    link.syncIn = 1'b0;
    link.clrErr = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset wordOut", obsWordOut, 8'h00);
    checkOutput("reset wordValid", obsValid, 1'b0);
    checkOutput("reset locked", obsLocked, 1'b0);
    checkOutput("reset errCnt", obsErr, 2'd0);
    rst_n = 1'b1;

    // Clean lock from reset
    clearRx();
    for (int w = 0; w < 7; w++) begin
      sendWord(8'(w), 8'h01, -1);
      if (w == 3) c3 = lastSyncCyc;
    end
    checkOutput("lock rise cycle", lockRiseCyc, c3 + 2);
    checkOutput("first words count", rxQ.size(), 3);
    checkOutput("first word", rxAt(0), 8'h03);
    checkOutput("second word", rxAt(1), 8'h04);
    checkOutput("third word", rxAt(2), 8'h05);
    checkOutput("first valid cycle", cycAt(0), c3 + 9);
    checkOutput("word spacing", cycAt(1) - cycAt(0), 8);
    checkOutput("clean errCnt", obsErr, 2'd0);

    // Bit order
    clearRx();
    sendWord(8'hA5, 8'h01, -1);
    sendWord(8'h3C, 8'h01, -1);
    sendWord(8'h11, 8'h01, -1);
    checkOutput("bit order count", rxQ.size(), 3);
    checkOutput("word A5", rxAt(1), 8'hA5);
    checkOutput("word 3C", rxAt(2), 8'h3C);
    checkOutput("wordOut holds", obsWordOut, 8'h3C);
    checkOutput("single pulse", pulseErr, 0);

    // Misplaced SYNC on bit 3 realigns the frame to bit 3
    clearRx();
    sendWord(8'h55, 8'h09, -1);
    cMis = lastSyncCyc;
    checkOutput("misplaced lock fall", lockFallCyc, cMis + 2);
    sendWord(8'h12, 8'h08, -1);
    sendWord(8'h34, 8'h08, -1);
    sendWord(8'hF0, 8'h08, -1);
    cX = lastSyncCyc;
    sendWord(8'h05, 8'h08, -1);
    checkOutput("misplaced relock", lockRiseCyc, cX + 2);
    checkOutput("misplaced errCnt", obsErr, 2'd1);
    checkOutput("misplaced count", rxQ.size(), 2);
    checkOutput("pre-error word", rxAt(0), 8'h11);
    checkOutput("realigned word", rxAt(1), 8'hBE);

    // Reset at bit 4 of a locked word, asynchronously
    for (int b = 0; b < 4; b++) applyStimulus(b < 3, b == 3, 1'b0);
    checkOutput("locked before reset", obsLocked, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("strobe before reset", link.wordValid, 1'b1);
    checkOutput("word before reset", link.wordOut, 8'hE0);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset wordOut", link.wordOut, 8'h00);
    checkOutput("async reset wordValid", link.wordValid, 1'b0);
    checkOutput("async reset locked", link.locked, 1'b0);
    checkOutput("async reset errCnt", link.syncErrCnt, 2'd0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    clearRx();
    for (int w = 16; w < 21; w++) begin
      sendWord(8'(w), 8'h01, -1);
      if (w == 19) c13 = lastSyncCyc;
    end
    checkOutput("post-reset relock", lockRiseCyc, c13 + 2);
    checkOutput("post-reset count", rxQ.size(), 1);
    checkOutput("post-reset first word", rxAt(0), 8'h13);

    // Missing SYNC
    clearRx();
    sendWord(8'h66, 8'h00, -1);
    c66 = lastBit0Cyc;
    checkOutput("missing lock fall", lockFallCyc, c66 + 2);
    checkOutput("missing errCnt", obsErr, 2'd1);
    checkOutput("missing locked", obsLocked, 1'b0);
    for (int w = 32; w < 36; w++) begin
      sendWord(8'(w), 8'h01, -1);
      if (w == 35) c23 = lastSyncCyc;
    end
    checkOutput("missing relock", lockRiseCyc, c23 + 2);
    checkOutput("missing word dropped", rxQ.size(), 1);
    checkOutput("word before miss", rxAt(0), 8'h14);

    // Saturation and clear
    sendWord(8'h24, 8'h01, 2);
    checkOutput("clear from 1", obsErr, 2'd0);
    for (int i = 0; i < 5; i++) begin
      sendWord(8'h30, 8'h00, -1);
      for (int j = 0; j < 4; j++) sendWord(8'(8'h31 + j), 8'h01, -1);
      if (i == 1) checkOutput("two errors", obsErr, 2'd2);
    end
    checkOutput("saturated errCnt", obsErr, 2'd3);
    checkOutput("relocked after errors", obsLocked, 1'b1);
    sendWord(8'h40, 8'h00, 1);
    checkOutput("clear with error", obsErr, 2'd1);
    for (int j = 0; j < 4; j++) sendWord(8'(8'h41 + j), 8'h01, -1);
    sendWord(8'h45, 8'h01, 3);
    checkOutput("clear alone", obsErr, 2'd0);
    checkOutput("final locked", obsLocked, 1'b1);
    checkOutput("final single pulse", pulseErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
